// File: rtl/vid2is_pkg.sv
// Shared definitions for the video-to-image-stream FIFO writer: framing states,
// header value and the 17-bit {count, stable} measurement format.
package vid2is_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACTIVE,
        ST_ACTIVE,
        ST_FLUSH,
        ST_DROP
    } state_t;

    localparam int unsigned HEADER_VALUE = 0;
    localparam int unsigned COUNT_W      = 16;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic               stable;
    } count17_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vid2is_res_detect.sv
// Measures active samples per line, active lines per field (per field id)
// and interlace / next-field prediction from the qualified video timing.
module vid2is_res_detect
    import vid2is_pkg::*;
(
    input  logic     vid_clk,
    input  logic     rst_n,
    input  logic     valid,
    input  logic     de,
    input  logic     vs_edge,
    input  logic     field,
    output count17_t sample_count,
    output count17_t line_count_f0,
    output count17_t line_count_f1,
    output logic     is_interlaced,
    output logic     is_field_prediction
);

    logic                de_prev;
    logic                de_fall;
    logic [COUNT_W-1:0]  sample_cnt;
    logic [COUNT_W-1:0]  line_cnt;
    logic [COUNT_W-1:0]  lines_total;
    logic                last_f;
    logic                seen_field;

    assign de_fall = valid & de_prev & ~de;

    // A line ending on the same cycle as the field edge still belongs to that field.
    assign lines_total = de_fall ? sat_inc(line_cnt) : line_cnt;

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev             <= 1'b0;
            sample_cnt          <= '0;
            line_cnt            <= '0;
            sample_count        <= '0;
            line_count_f0       <= '0;
            line_count_f1       <= '0;
            is_interlaced       <= 1'b0;
            is_field_prediction <= 1'b0;
            last_f              <= 1'b0;
            seen_field          <= 1'b0;
        end else begin
            if (valid) de_prev <= de;
            if (valid && de) sample_cnt <= sat_inc(sample_cnt);
            if (de_fall) begin
                sample_cnt   <= '0;
                sample_count <= '{count: sample_cnt, stable: (sample_cnt == sample_count.count)};
                line_cnt     <= sat_inc(line_cnt);
            end
            if (vs_edge) begin
                line_cnt <= '0;
                if (lines_total != '0) begin
                    if (field)
                        line_count_f1 <= '{count: lines_total, stable: (lines_total == line_count_f1.count)};
                    else
                        line_count_f0 <= '{count: lines_total, stable: (lines_total == line_count_f0.count)};
                end
                is_interlaced       <= seen_field & (field != last_f);
                is_field_prediction <= ~field;
                last_f              <= field;
                seen_field          <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vid2is_fifo_writer.sv
// Frames qualified active video into FIFO packets: a header word, the samples,
// and exactly one last-flagged word per header, with overflow handling.
module vid2is_fifo_writer
    import vid2is_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int FIFO_WIDTH = DATA_WIDTH + 1
) (
    input  logic                  vid_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  vid_datavalid,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  vid_de,
    input  logic                  vid_v_sync,
    input  logic                  vid_f,
    input  logic                  wrfull,
    output logic                  wrreq,
    output logic [FIFO_WIDTH-1:0] data,
    output logic [16:0]           is_active_sample_count,
    output logic [16:0]           is_active_line_count_f0,
    output logic [16:0]           is_active_line_count_f1,
    output logic                  is_interlaced,
    output logic                  is_field_prediction,
    output logic                  overflow
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic [FIFO_WIDTH-1:0] data_nxt;
    logic                  wr_nxt;
    logic                  skip, skip_nxt;
    logic                  overflow_nxt;
    logic                  vs_prev;
    logic                  de_q;
    logic                  vs_edge;
    count17_t              sample_count, line_count_f0, line_count_f1;

    assign de_q    = vid_datavalid & vid_de;
    assign vs_edge = vid_datavalid & vid_v_sync & ~vs_prev;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold;
        skip_nxt     = skip;
        overflow_nxt = overflow;
        wr_nxt       = 1'b0;
        data_nxt     = data;

        if (vs_edge && !enable) overflow_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (vs_edge && enable) state_nxt = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                if (vs_edge) begin
                    if (!enable) state_nxt = ST_IDLE;
                end else if (de_q && !skip) begin
                    if (wrfull) begin
                        overflow_nxt = 1'b1;
                        skip_nxt     = 1'b1;
                    end else begin
                        wr_nxt    = 1'b1;
                        data_nxt  = {DATA_WIDTH'(HEADER_VALUE), 1'b0};
                        hold_nxt  = vid_data;
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (de_q) begin
                    if (wrfull) begin
                        overflow_nxt = 1'b1;
                        skip_nxt     = 1'b1;
                        state_nxt    = ST_DROP;
                    end else begin
                        wr_nxt   = 1'b1;
                        data_nxt = {hold, 1'b0};
                        hold_nxt = vid_data;
                    end
                end
                if (vs_edge && state_nxt == ST_ACTIVE) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Closing word may use the FIFO's one-word headroom.
                wr_nxt    = 1'b1;
                data_nxt  = {hold, 1'b1};
                state_nxt = enable ? ST_WAIT_ACTIVE : ST_IDLE;
            end
            ST_DROP: begin
                if (!wrfull) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = {hold, 1'b1};
                    state_nxt = ST_WAIT_ACTIVE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The rest of a truncated field is skipped; any field edge ends the skip.
        if (vs_edge) skip_nxt = 1'b0;
    end

    // NOTE: the hold register is reset along with the rest so a packet can never
    // carry stale pixel data out of reset.
    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold     <= '0;
            skip     <= 1'b0;
            overflow <= 1'b0;
            vs_prev  <= 1'b0;
            wrreq    <= 1'b0;
            data     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments only.
            state    <= state_nxt;
            hold     <= hold_nxt;
            skip     <= skip_nxt;
            overflow <= overflow_nxt;
            if (vid_datavalid) vs_prev <= vid_v_sync;
            wrreq    <= wr_nxt;
            data     <= data_nxt;
        end
    end

    vid2is_res_detect u_res_detect (
        .vid_clk             (vid_clk),
        .rst_n               (rst_n),
        .valid               (vid_datavalid),
        .de                  (vid_de),
        .vs_edge             (vs_edge),
        .field               (vid_f),
        .sample_count        (sample_count),
        .line_count_f0       (line_count_f0),
        .line_count_f1       (line_count_f1),
        .is_interlaced       (is_interlaced),
        .is_field_prediction (is_field_prediction)
    );

    assign is_active_sample_count  = sample_count;
    assign is_active_line_count_f0 = line_count_f0;
    assign is_active_line_count_f1 = line_count_f1;

endmodule

// File: tb/tb_vid2is_fifo_writer.sv
// Randomized bench for vid2is_fifo_writer: a field-level reference model feeds a
// word scoreboard consumed by a monitor; status outputs are checked at field edges.
module tb_vid2is_fifo_writer;

    localparam int DW = 20;
    localparam int FW = DW + 1;

    logic          vid_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          vid_datavalid = 1'b0;
    logic [DW-1:0] vid_data = '0;
    logic          vid_de = 1'b0;
    logic          vid_v_sync = 1'b0;
    logic          vid_f = 1'b0;
    logic          wrfull = 1'b0;
    logic          wrreq;
    logic [FW-1:0] data;
    logic [16:0]   sc, lc0, lc1;
    logic          is_interlaced, is_field_prediction, overflow;

    vid2is_fifo_writer #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW)) dut (
        .vid_clk                 (vid_clk),
        .rst_n                   (rst_n),
        .enable                  (enable),
        .vid_datavalid           (vid_datavalid),
        .vid_data                (vid_data),
        .vid_de                  (vid_de),
        .vid_v_sync              (vid_v_sync),
        .vid_f                   (vid_f),
        .wrfull                  (wrfull),
        .wrreq                   (wrreq),
        .data                    (data),
        .is_active_sample_count  (sc),
        .is_active_line_count_f0 (lc0),
        .is_active_line_count_f1 (lc1),
        .is_interlaced           (is_interlaced),
        .is_field_prediction     (is_field_prediction),
        .overflow                (overflow)
    );

    always #5 vid_clk = ~vid_clk;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] sb[$];

    // Reference model state
    bit          captured = 0, dv_toggle = 0;
    int          wf_lo = 0, wf_hi = 0;
    int          s_latch = 0, l0 = 0, l1 = 0, lines_in_field = 0;
    bit          last_f = 0, seen = 0, m_il = 0, m_pred = 0, m_ovf = 0;
    logic [16:0] m_sc = '0, m_lc0 = '0, m_lc1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic dv, input logic de, input logic vs, input logic [DW-1:0] d);
        vid_datavalid = dv;
        vid_de        = de;
        vid_v_sync    = vs;
        vid_data      = d;
        @(posedge vid_clk);
        #1;
    endtask

    // One qualified cycle, optionally preceded by an unqualified cycle of junk.
    task automatic send(input logic de, input logic vs, input logic [DW-1:0] d);
        logic f_keep;
        f_keep = vid_f;
        if (dv_toggle) begin
            vid_f = 1'($urandom);
            step(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
            vid_f = f_keep;
        end
        step(1'b1, de, vs, d);
    endtask

    task automatic model_reset();
        captured = 0; s_latch = 0; l0 = 0; l1 = 0; lines_in_field = 0;
        last_f = 0; seen = 0; m_il = 0; m_pred = 0; m_ovf = 0;
        m_sc = '0; m_lc0 = '0; m_lc1 = '0;
    endtask

    task automatic do_reset();
        send(1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wrreq", 64'(wrreq), 0);
        check("rst_data", 64'(data), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_counts", {13'd0, sc, lc0, lc1}, 0);
        check("rst_flags", {is_interlaced, is_field_prediction}, 0);
        check("rst_pending_words", sb.size(), 0);
        model_reset();
        @(posedge vid_clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic body(input int w, input int h, input bit f, input int en_off_line, input int rst_line);
        logic [DW-1:0] s[$];
        int n;
        int k;
        n = w * h;
        k = 0;
        vid_f = f;
        for (int i = 0; i < n; i++) s.push_back(DW'($urandom));
        if (captured && n > 0) begin
            if (rst_line > 0) begin
                sb.push_back('0);
                for (int i = 0; i < rst_line * w - 1; i++) sb.push_back({s[i], 1'b0});
            end else if (wf_lo > 0) begin
                m_ovf = 1;
                if (wf_lo > 1) begin
                    sb.push_back('0);
                    for (int i = 0; i < wf_lo - 1; i++) sb.push_back({s[i], 1'(i == wf_lo - 2)});
                end
            end else begin
                sb.push_back('0);
                for (int i = 0; i < n; i++) sb.push_back({s[i], 1'(i == n - 1)});
            end
        end
        for (int ln = 0; ln < h; ln++) begin
            send(1'b0, 1'b0, '0);
            send(1'b0, 1'b0, '0);
            for (int x = 0; x < w; x++) begin
                k++;
                if (k == wf_lo) wrfull = 1'b1;
                if (k == wf_hi + 1) wrfull = 1'b0;
                send(1'b1, 1'b0, s[k-1]);
            end
            m_sc = {16'(w), 1'(w == s_latch)};
            s_latch = w;
            lines_in_field++;
            if (ln + 1 == en_off_line) enable = 1'b0;
            if (ln + 1 == rst_line) do_reset();
        end
        wrfull = 1'b0;
        wf_lo = 0;
        wf_hi = 0;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
    endtask

    task automatic boundary(input bit en);
        enable = en;
        send(1'b0, 1'b0, '0);
        if (lines_in_field > 0) begin
            if (vid_f) begin
                m_lc1 = {16'(lines_in_field), 1'(lines_in_field == l1)};
                l1 = lines_in_field;
            end else begin
                m_lc0 = {16'(lines_in_field), 1'(lines_in_field == l0)};
                l0 = lines_in_field;
            end
        end
        lines_in_field = 0;
        m_il   = seen && (vid_f != last_f);
        m_pred = !vid_f;
        last_f = vid_f;
        seen   = 1;
        if (!en) m_ovf = 0;
        captured = en;
        send(1'b0, 1'b1, '0);
        send(1'b0, 1'b1, '0);
        repeat (3) send(1'b0, 1'b0, '0);
        check("sample_count", 64'(sc), 64'(m_sc));
        check("line_count_f0", 64'(lc0), 64'(m_lc0));
        check("line_count_f1", 64'(lc1), 64'(m_lc1));
        check("is_interlaced", 64'(is_interlaced), 64'(m_il));
        check("is_field_prediction", 64'(is_field_prediction), 64'(m_pred));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // Monitor: every write must match the next expected word and never follow a full cycle.
    initial begin : monitor
        logic          wf_prev;
        logic [FW-1:0] exp;
        wf_prev = 1'b0;
        forever begin
            @(negedge vid_clk);
            if (rst_n && wrreq) begin
                check("write_after_full", 64'(wf_prev), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got %0h expected no write at %0t", data, $time);
                end else begin
                    exp = sb.pop_front();
                    check("fifo_word", 64'(data), 64'(exp));
                end
            end
            wf_prev = wrfull;
        end
    end

    initial begin : stimulus
        int w, h, n;
        bit f, en;
        repeat (2) @(posedge vid_clk);
        #1;
        check("reset_wrreq", 64'(wrreq), 0);
        check("reset_data", 64'(data), 0);
        check("reset_status", {sc, lc0, lc1, is_interlaced, is_field_prediction, overflow}, 0);
        rst_n = 1'b1;
        repeat (3) send(1'b0, 1'b0, '0);
        boundary(1);

        // Progressive 4x3, two fields
        body(4, 3, 0, 0, 0); boundary(1);
        body(4, 3, 0, 0, 0); boundary(1);
        check("prog_sample_count", 64'(sc), 64'h9);
        check("prog_line_count_f0", 64'(lc0), 64'h7);

        // Same pictures with the qualifier toggling every cycle
        dv_toggle = 1;
        body(4, 3, 0, 0, 0); boundary(1);
        body(4, 3, 0, 0, 0); boundary(1);
        dv_toggle = 0;

        // Alternating field ids
        body(5, 2, 1, 0, 0); boundary(1);
        check("interlaced_after_f1", 64'(is_interlaced), 1);
        body(4, 3, 0, 0, 0); boundary(1);
        body(5, 2, 1, 0, 0); boundary(1);

        // FIFO full from sample 6 to 9, then a complete field
        wf_lo = 6; wf_hi = 9;
        body(4, 3, 0, 0, 0); boundary(1);
        check("overflow_sticky", 64'(overflow), 1);
        body(4, 3, 1, 0, 0); boundary(1);

        // Reset in the middle of an active field
        body(4, 3, 0, 0, 2); boundary(1);
        body(4, 3, 1, 0, 0); boundary(1);

        // Enable dropped mid-field
        body(4, 3, 0, 1, 0); boundary(0);
        body(4, 3, 1, 0, 0); boundary(1);
        body(3, 2, 0, 0, 0); boundary(1);

        // Random fields
        for (int r = 0; r < 10; r++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(0, 4);
            n = w * h;
            f = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            dv_toggle = 1'($urandom);
            if (n > 2 && $urandom_range(0, 2) == 0) begin
                wf_lo = $urandom_range(1, n - 1);
                wf_hi = $urandom_range(wf_lo, n - 1);
            end
            body(w, h, f, 0, 0);
            boundary(en);
        end
        dv_toggle = 0;
        body(2, 2, 0, 0, 0); boundary(1);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge vid_clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
